// File: rtl/nic_tx_sched.sv
// Four-requester round-robin transmit scheduler for a polled NIC output buffer.
// Each grant polls the NIC output status, then writes the latched packet, or drops it on poll timeout.
module nic_tx_sched #(
    parameter int POLL_LIMIT = 255
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [0:3]   req,
    input  logic [0:255] req_data,
    output logic [0:3]   gnt,
    output logic [0:3]   done,
    output logic [0:3]   err,
    output logic         busy,
    output logic         nicEn,
    output logic         nicEnWr,
    output logic [0:1]   addr,
    output logic [0:63]  d_in,
    input  logic [0:63]  d_out
);

    typedef enum logic [2:0] {S_IDLE, S_POLL, S_WRITE, S_DONE, S_ERR} state_t;

    state_t      state, state_nxt;
    logic [1:0]  rr_ptr;
    logic [1:0]  g_idx;
    logic [7:0]  poll_cnt;
    logic [0:63] pkt_reg;

    logic        found;
    logic [1:0]  win;
    logic [0:3]  win_oh;
    logic        out_sts;
    logic        poll_last;

    assign out_sts   = d_out[63];
    assign poll_last = (poll_cnt == 8'(POLL_LIMIT - 1));

    // Only the status bit is consumed; the rest of the read word is ignored.
    logic unused_dout;
    assign unused_dout = ^d_out[0:62];

    // Walk the search order from the far end so the entry nearest rr_ptr wins.
    always_comb begin
        logic [1:0] idx;
        found  = 1'b0;
        win    = rr_ptr;
        idx    = '0;
        win_oh = '0;
        for (int k = 3; k >= 0; k--) begin
            idx = rr_ptr + 2'(k);
            if (req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        win_oh[win] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            rr_ptr   <= '0;
            g_idx    <= '0;
            poll_cnt <= '0;
            pkt_reg  <= '0;
            gnt      <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: if (found) begin
                    pkt_reg  <= req_data[{win, 6'b0} +: 64];
                    gnt      <= win_oh;
                    g_idx    <= win;
                    poll_cnt <= '0;
                end
                S_POLL: if (out_sts && !poll_last) poll_cnt <= poll_cnt + 8'd1;
                S_DONE, S_ERR: begin
                    rr_ptr <= g_idx + 2'd1;
                    gnt    <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (found) state_nxt = S_POLL;
            S_POLL: begin
                if (!out_sts)       state_nxt = S_WRITE;
                else if (poll_last) state_nxt = S_ERR;
            end
            S_WRITE: state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // NIC drive decodes from registered state only, so reset drops it without a clock.
    always_comb begin
        nicEn   = 1'b0;
        nicEnWr = 1'b0;
        addr    = 2'b00;
        d_in    = '0;
        done    = '0;
        err     = '0;
        case (state)
            S_POLL: begin
                nicEn = 1'b1;
                addr  = 2'b11;
            end
            S_WRITE: begin
                nicEn   = 1'b1;
                nicEnWr = 1'b1;
                addr    = 2'b10;
                d_in    = pkt_reg;
            end
            S_DONE:  done = gnt;
            S_ERR:   err  = gnt;
            default: ;
        endcase
    end

    assign busy = (state != S_IDLE);

endmodule
